// File: rtl/eth_ctrl_pkg.sv
// Shared encodings for the Ethernet control path: arbiter FSM states and
// TX owner identifiers (which also serve as the TX mux select values).
package eth_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_CMD = 2'd1,
        ST_GRANT_PIC = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_e;

    localparam logic OWNER_CMD = 1'b0;
    localparam logic OWNER_PIC = 1'b1;

endpackage

// File: rtl/eth_tx_arbiter.sv
// Arbitrates the shared RGMII TX path between the command sender and the picture
// engine, with an inter-frame guard gap and a watchdog on held grants.
module eth_tx_arbiter
    import eth_ctrl_pkg::*;
#(
    parameter int unsigned IFG_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 25000000,
    parameter int unsigned CNT_W          = 25,
    parameter int unsigned CMD_PRIORITY   = 1
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic cmd_req,
    input  logic cmd_done,
    output logic cmd_grant,
    input  logic pic_req,
    input  logic pic_done,
    output logic pic_grant,
    output logic tx_sel,
    output logic busy,
    output logic timeout_err,
    output logic last_owner
);

    localparam logic [CNT_W-1:0] IfgLast     = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_sel_q, tx_sel_d;
    logic             last_owner_q, last_owner_d;
    logic             timeout_d;
    logic             cmd_grant_q, pic_grant_q, busy_q, timeout_err_q;
    logic             winner;
    logic             own_req, own_done;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_sel_d     = tx_sel_q;
        last_owner_d = last_owner_q;
        timeout_d    = 1'b0;

        // Tie break: fixed cmd priority, or hand the bus to whoever did not have it last.
        winner = OWNER_CMD;
        if (cmd_req && pic_req) begin
            winner = (CMD_PRIORITY != 0) ? OWNER_CMD : ~last_owner_q;
        end else if (pic_req) begin
            winner = OWNER_PIC;
        end

        own_req  = (state_q == ST_GRANT_PIC) ? pic_req  : cmd_req;
        own_done = (state_q == ST_GRANT_PIC) ? pic_done : cmd_done;

        case (state_q)
            ST_IDLE: begin
                if (cmd_req || pic_req) begin
                    state_d      = (winner == OWNER_PIC) ? ST_GRANT_PIC : ST_GRANT_CMD;
                    cnt_d        = '0;
                    tx_sel_d     = winner;
                    last_owner_d = winner;
                end
            end
            ST_GRANT_CMD, ST_GRANT_PIC: begin
                // done and abandon take precedence over the watchdog
                if (own_done || !own_req) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == IfgLast) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are flops decoded from next state so they align with the state change.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tx_sel_q      <= OWNER_CMD;
            last_owner_q  <= OWNER_CMD;
            cmd_grant_q   <= 1'b0;
            pic_grant_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_sel_q      <= tx_sel_d;
            last_owner_q  <= last_owner_d;
            cmd_grant_q   <= (state_d == ST_GRANT_CMD);
            pic_grant_q   <= (state_d == ST_GRANT_PIC);
            busy_q        <= (state_d != ST_IDLE);
            timeout_err_q <= timeout_d;
        end
    end

    assign cmd_grant   = cmd_grant_q;
    assign pic_grant   = pic_grant_q;
    assign tx_sel      = tx_sel_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign last_owner  = last_owner_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: one fixed-priority and one round-robin
// instance share stimulus; a cycle-level reference model predicts output changes.
module tb_eth_tx_arbiter;

    localparam int unsigned IFG = 16;
    localparam int unsigned TMO = 100;

    typedef struct packed {
        int unsigned cyc;
        logic [5:0]  outs;  // {cmd_grant, pic_grant, tx_sel, busy, timeout_err, last_owner}
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       cmd_req, cmd_done, pic_req, pic_done;
    logic [1:0] cmd_grant, pic_grant, tx_sel, busy, timeout_err, last_owner;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    // Reference model state, index 0 = cmd priority, 1 = round robin
    int         own_m  [2];  // -1 none, 0 cmd, 1 pic
    int         held_m [2];
    int         gap_m  [2];
    logic       sel_m  [2];
    logic       lo_m   [2];
    logic       terr_m [2];
    logic [5:0] last_m [2];
    exp_t       q0[$];
    exp_t       q1[$];

    logic       mon_en = 1'b0;
    logic [5:0] prev_v [2];
    logic [5:0] mon_v;
    exp_t       mon_e;

    eth_tx_arbiter #(
        .IFG_CYCLES    (IFG),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (8),
        .CMD_PRIORITY  (1)
    ) u_dut_prio (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cmd_req    (cmd_req),
        .cmd_done   (cmd_done),
        .cmd_grant  (cmd_grant[0]),
        .pic_req    (pic_req),
        .pic_done   (pic_done),
        .pic_grant  (pic_grant[0]),
        .tx_sel     (tx_sel[0]),
        .busy       (busy[0]),
        .timeout_err(timeout_err[0]),
        .last_owner (last_owner[0])
    );

    eth_tx_arbiter #(
        .IFG_CYCLES    (IFG),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (8),
        .CMD_PRIORITY  (0)
    ) u_dut_rr (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cmd_req    (cmd_req),
        .cmd_done   (cmd_done),
        .cmd_grant  (cmd_grant[1]),
        .pic_req    (pic_req),
        .pic_done   (pic_done),
        .pic_grant  (pic_grant[1]),
        .tx_sel     (tx_sel[1]),
        .busy       (busy[1]),
        .timeout_err(timeout_err[1]),
        .last_owner (last_owner[1])
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [5:0] outs_of(input int d);
        return {cmd_grant[d], pic_grant[d], tx_sel[d], busy[d], timeout_err[d], last_owner[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            own_m[d]  = -1;
            held_m[d] = 0;
            gap_m[d]  = 0;
            sel_m[d]  = 1'b0;
            lo_m[d]   = 1'b0;
            terr_m[d] = 1'b0;
            last_m[d] = 6'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Advance the model over the next clock edge with the inputs now applied,
    // and queue the outputs expected after that edge if they differ.
    task automatic model_step(input logic cr, input logic cd, input logic pr, input logic pd);
        logic       rq, dn;
        int         w;
        logic [5:0] s;
        exp_t       e;
        for (int d = 0; d < 2; d++) begin
            terr_m[d] = 1'b0;
            if (own_m[d] >= 0) begin
                rq = (own_m[d] == 1) ? pr : cr;
                dn = (own_m[d] == 1) ? pd : cd;
                if (dn || !rq) begin
                    own_m[d] = -1;
                    gap_m[d] = IFG;
                end else if (held_m[d] == TMO - 1) begin
                    own_m[d]  = -1;
                    gap_m[d]  = IFG;
                    terr_m[d] = 1'b1;
                end else begin
                    held_m[d]++;
                end
            end else if (gap_m[d] > 0) begin
                gap_m[d]--;
            end else if (cr || pr) begin
                if (cr && pr) w = (d == 0) ? 0 : (lo_m[d] ? 0 : 1);
                else          w = pr ? 1 : 0;
                own_m[d]  = w;
                held_m[d] = 0;
                sel_m[d]  = (w == 1);
                lo_m[d]   = (w == 1);
            end
            s = {own_m[d] == 0, own_m[d] == 1, sel_m[d], (own_m[d] >= 0) || (gap_m[d] > 0),
                 terr_m[d], lo_m[d]};
            if (s != last_m[d]) begin
                e.cyc  = cyc + 1;
                e.outs = s;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                last_m[d] = s;
            end
        end
    endtask

    task automatic step(input logic cr, input logic cd, input logic pr, input logic pd);
        @(posedge sys_clk);
        #1;
        cmd_req  = cr;
        cmd_done = cd;
        pic_req  = pr;
        pic_done = pd;
        model_step(cr, cd, pr, pd);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string name, input int d, input logic [5:0] want);
        n_tests++;
        if (outs_of(d) !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%b want=%b", name, d, outs_of(d), want);
        end
    endtask

    task automatic run_random(input int n);
        logic cr, pr, drop_c, drop_p, cd, pd;
        cr = 1'b0; pr = 1'b0; drop_c = 1'b0; drop_p = 1'b0;
        for (int i = 0; i < n; i++) begin
            cd = 1'b0;
            pd = 1'b0;
            if (drop_c) begin
                cr = 1'b0; drop_c = 1'b0;
            end else if (!cr) begin
                if ($urandom_range(7) == 0) cr = 1'b1;
                else if ($urandom_range(49) == 0) cd = 1'b1;
            end else if ($urandom_range(19) == 0) begin
                cd = 1'b1; drop_c = 1'b1;
            end else if ($urandom_range(199) == 0) begin
                cr = 1'b0;
            end
            if (drop_p) begin
                pr = 1'b0; drop_p = 1'b0;
            end else if (!pr) begin
                if ($urandom_range(7) == 0) pr = 1'b1;
                else if ($urandom_range(49) == 0) pd = 1'b1;
            end else if ($urandom_range(19) == 0) begin
                pd = 1'b1; drop_p = 1'b1;
            end else if ($urandom_range(199) == 0) begin
                pr = 1'b0;
            end
            step(cr, cd, pr, pd);
        end
    endtask

    // Monitor: every output change must match the next queued prediction.
    always @(negedge sys_clk) begin
        for (int d = 0; d < 2; d++) begin
            mon_v = outs_of(d);
            if (mon_en) begin
                n_tests++;
                if ((mon_v[5] && mon_v[4]) || ((mon_v[5] || mon_v[4]) && !mon_v[2])) begin
                    n_fail++;
                    $display("FAIL grant_excl dut%0d cyc=%0d got=%b want=single grant with busy",
                             d, cyc, mon_v);
                end
                if (mon_v != prev_v[d]) begin
                    n_tests++;
                    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_change dut%0d cyc=%0d got=%b want=%b",
                                 d, cyc, mon_v, prev_v[d]);
                    end else begin
                        if (d == 0) mon_e = q0.pop_front();
                        else        mon_e = q1.pop_front();
                        if (mon_e.cyc != cyc || mon_e.outs != mon_v) begin
                            n_fail++;
                            $display("FAIL out_change dut%0d got cyc=%0d outs=%b want cyc=%0d outs=%b",
                                     d, cyc, mon_v, mon_e.cyc, mon_e.outs);
                        end
                    end
                end
            end
            prev_v[d] = mon_v;
        end
    end

    initial begin
        rst_n    = 1'b0;
        cmd_req  = 1'b0;
        cmd_done = 1'b0;
        pic_req  = 1'b0;
        pic_done = 1'b0;
        prev_v[0] = 6'b0;
        prev_v[1] = 6'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #3;
        for (int d = 0; d < 2; d++) check_outs("reset_state", d, 6'b0);
        rst_n = 1'b1;
        model_step(cmd_req, cmd_done, pic_req, pic_done);
        mon_en = 1'b1;

        // Single cmd frame, then guard gap
        idle(5);
        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(25);

        // Two ties back to back
        repeat (2) begin
            repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b1);
            idle(20);
        end

        // pic held past the watchdog; stray cmd_done while pic owns the bus
        for (int i = 0; i < 130; i++) step(1'b0, (i == 50), 1'b1, 1'b0);
        idle(30);

        // pic_done lands on the watchdog cycle
        for (int i = 0; i <= 100; i++) step(1'b0, 1'b0, 1'b1, (i == 100));
        idle(30);

        // Asynchronous reset during a pic grant, cmd_req held across it
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge sys_clk);
        #3;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_outs("async_reset", d, 6'b0);
        model_reset();
        pic_req = 1'b0;
        cmd_req = 1'b1;
        repeat (2) @(posedge sys_clk);
        #3;
        rst_n = 1'b1;
        model_step(cmd_req, cmd_done, pic_req, pic_done);
        mon_en = 1'b1;
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(25);

        run_random(4000);
        idle(40);

        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut0 got=%0d pending want=0", q0.size());
        end
        n_tests++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut1 got=%0d pending want=0", q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
